// File: rtl/exception_monitor.sv
// Runtime exception monitor: captures divisor operands per program, flags
// divide-by-zero at a per-program check PC and PC-out-of-range, and holds a
// sticky record drained by a valid/ack handshake.
// Ports: CLK, Reset (async high); ProgState, Instruction, PC, DataIn snooped;
// exc_ack drains; exc_valid/cause/prog/pc record, exc_overflow, exc_count,
// operand (lane 0 in the MSBs).
module exception_monitor #(
    parameter int DATA_W    = 8,
    parameter int PC_W      = 10,
    parameter int NUM_LANES = 2,
    parameter int LANES_P1  = 2,
    parameter int LANES_P2  = 1,
    parameter int LANES_P3  = 2,
    parameter int BASE_P1   = 0,
    parameter int BASE_P2   = 2,
    parameter int BASE_P3   = 0,
    parameter logic [PC_W-1:0] CHK_PC_P1 = 10'h03A,
    parameter logic [PC_W-1:0] CHK_PC_P2 = 10'h08D,
    parameter logic [PC_W-1:0] CHK_PC_P3 = 10'h3FF,
    parameter logic [PC_W-1:0] PC_LIMIT  = 10'h3F0,
    parameter int CNT_W     = 4
) (
    input  logic                        CLK,
    input  logic                        Reset,
    input  logic [1:0]                  ProgState,
    input  logic [8:0]                  Instruction,
    input  logic [PC_W-1:0]             PC,
    input  logic [DATA_W-1:0]           DataIn,
    input  logic                        exc_ack,
    output logic                        exc_valid,
    output logic [1:0]                  exc_cause,
    output logic [1:0]                  exc_prog,
    output logic [PC_W-1:0]             exc_pc,
    output logic                        exc_overflow,
    output logic [CNT_W-1:0]            exc_count,
    output logic [NUM_LANES*DATA_W-1:0] operand
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_PEND  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] lane [NUM_LANES];
    logic [PC_W-1:0]   prev_pc;
    logic [1:0]        prev_ps;
    logic              seen;

    int              nlanes;
    int              base;
    int              k;
    logic [PC_W-1:0] chk;
    logic            active, is_lw, all_zero, held;
    logic            zero_hit, range_hit, det;
    logic            lane_clr, accept, drain;

    always_comb begin
        nlanes = 0;
        base   = 0;
        chk    = '1;
        case (ProgState)
            2'd1: begin nlanes = LANES_P1; base = BASE_P1; chk = CHK_PC_P1; end
            2'd2: begin nlanes = LANES_P2; base = BASE_P2; chk = CHK_PC_P2; end
            2'd3: begin nlanes = LANES_P3; base = BASE_P3; chk = CHK_PC_P3; end
            default: ;
        endcase
    end

    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (i < nlanes && lane[i] != '0) all_zero = 1'b0;
        end
    end

    assign active = (ProgState != 2'd0);
    assign is_lw  = (Instruction[8:6] == 3'b000) && (Instruction[2:0] == 3'b111);
    assign k      = int'(Instruction[5:3]) - base;

    // Edge rule: a held PC (stall) must not re-trigger a check.
    assign held      = seen && (PC == prev_pc);
    assign zero_hit  = active && (chk != '1) && (PC == chk) && !held && all_zero;
    assign range_hit = active && (PC > PC_LIMIT) && !(seen && prev_pc > PC_LIMIT);
    assign det       = zero_hit || range_hit;

    assign lane_clr = !active || (prev_ps != 2'd0 && ProgState != prev_ps);
    assign accept   = det && (state != S_PEND || exc_ack);
    assign drain    = (state == S_PEND) && exc_ack;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (det)         state_nx = S_PEND;
                else if (active) state_nx = S_ARMED;
            end
            S_ARMED: begin
                if (det)          state_nx = S_PEND;
                else if (!active) state_nx = S_IDLE;
            end
            S_PEND: begin
                if (exc_ack && !det) state_nx = active ? S_ARMED : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        exc_valid = (state == S_PEND);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            exc_cause    <= 2'b00;
            exc_prog     <= 2'b00;
            exc_pc       <= '0;
            exc_overflow <= 1'b0;
        end else if (accept) begin
            // Zero cause wins when both checks fire together.
            exc_cause    <= zero_hit ? 2'b01 : 2'b10;
            exc_prog     <= ProgState;
            exc_pc       <= PC;
            exc_overflow <= 1'b0;
        end else if (det) begin
            exc_overflow <= 1'b1;
        end else if (drain) begin
            exc_cause    <= 2'b00;
            exc_prog     <= 2'b00;
            exc_pc       <= '0;
            exc_overflow <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)                          exc_count <= '0;
        else if (det && exc_count != '1)    exc_count <= exc_count + CNT_W'(1);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_LANES; i++) lane[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_clr)
                    lane[i] <= '0;
                else if (is_lw && k == i && i < nlanes)
                    lane[i] <= DataIn;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            prev_pc <= '0;
            prev_ps <= 2'd0;
            seen    <= 1'b0;
        end else begin
            prev_pc <= PC;
            prev_ps <= ProgState;
            seen    <= active;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_op
        assign operand[(NUM_LANES-1-g)*DATA_W +: DATA_W] = lane[g];
    end

endmodule

// File: tb/tb_exception_monitor.sv
// Scoreboard bench for exception_monitor: directed scenarios plus random
// traffic, checked against a behavioural model of the monitor's rules.
module tb_exception_monitor;

    logic        CLK;
    logic        Reset;
    logic [1:0]  ProgState;
    logic [8:0]  Instruction;
    logic [9:0]  PC;
    logic [7:0]  DataIn;
    logic        exc_ack;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [1:0]  exc_prog;
    logic [9:0]  exc_pc;
    logic        exc_overflow;
    logic [3:0]  exc_count;
    logic [15:0] operand;

    exception_monitor dut (
        .CLK(CLK), .Reset(Reset), .ProgState(ProgState),
        .Instruction(Instruction), .PC(PC), .DataIn(DataIn),
        .exc_ack(exc_ack), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_prog(exc_prog), .exc_pc(exc_pc), .exc_overflow(exc_overflow),
        .exc_count(exc_count), .operand(operand)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        v;
        logic        o;
        logic [3:0]  c;
        logic [15:0] op;
    } cyc_t;

    typedef struct {
        logic [1:0] cause;
        logic [1:0] prog;
        logic [9:0] pc;
    } rec_t;

    cyc_t cq[$];
    rec_t rq[$];

    int n_pass  = 0;
    int n_total = 0;
    bit mon_en  = 0;
    bit last_valid = 0;

    int         LN [4] = '{0, 2, 1, 2};
    int         BS [4] = '{0, 0, 2, 0};
    logic [9:0] CK [4] = '{10'h3FF, 10'h03A, 10'h08D, 10'h3FF};

    // reference model state
    logic [7:0] m_lane [4];
    bit         m_pend, m_ovf, m_seen;
    int         m_cnt;
    logic [9:0] m_prev_pc;
    logic [1:0] m_prev_ps;

    localparam logic [8:0] NOP = 9'h100;

    function automatic logic [8:0] lw(input int r);
        return {3'b000, 3'(r), 3'b111};
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
        m_pend = 0; m_ovf = 0; m_seen = 0; m_cnt = 0;
        m_prev_pc = 10'h000; m_prev_ps = 2'd0;
    endtask

    task automatic model_step(input logic [1:0] ps, input logic [8:0] ins,
                              input logic [9:0] pc, input logic [7:0] din,
                              input logic ack);
        bit   act, zeros, zh, rh, det;
        int   n, k;
        rec_t r;
        cyc_t c;
        act   = (ps != 0);
        n     = LN[ps];
        zeros = 1;
        for (int i = 0; i < n; i++) if (m_lane[i] != 0) zeros = 0;
        zh = act && CK[ps] != 10'h3FF && pc == CK[ps]
             && !(m_seen && m_prev_pc == pc) && zeros;
        rh = act && pc > 10'h3F0 && !(m_seen && m_prev_pc > 10'h3F0);
        det = zh || rh;
        if (det && (!m_pend || ack)) begin
            m_pend = 1; m_ovf = 0;
            r.cause = zh ? 2'b01 : 2'b10;
            r.prog  = ps;
            r.pc    = pc;
            rq.push_back(r);
        end else if (det) begin
            m_ovf = 1;
        end else if (m_pend && ack) begin
            m_pend = 0; m_ovf = 0;
        end
        if (det && m_cnt < 15) m_cnt++;
        k = int'(ins[5:3]) - BS[ps];
        if (!act || (m_prev_ps != 0 && ps != m_prev_ps)) begin
            for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
        end else if (ins[8:6] == 3'b000 && ins[2:0] == 3'b111
                     && k >= 0 && k < n) begin
            m_lane[k] = din;
        end
        m_prev_pc = pc;
        m_prev_ps = ps;
        m_seen    = act;
        c.v  = m_pend;
        c.o  = m_ovf;
        c.c  = 4'(m_cnt);
        c.op = {m_lane[0], m_lane[1]};
        cq.push_back(c);
    endtask

    task automatic cyc(input logic [1:0] ps, input logic [8:0] ins,
                       input logic [9:0] pc, input logic [7:0] din,
                       input logic ack);
        @(negedge CLK);
        #1;
        ProgState   = ps;
        Instruction = ins;
        PC          = pc;
        DataIn      = din;
        exc_ack     = ack;
        model_step(ps, ins, pc, din, ack);
    endtask

    task automatic do_reset(input bit chk_out);
        mon_en = 0;
        Reset  = 1'b0;
        #1;
        Reset  = 1'b1;
        #1;
        if (chk_out) begin
            check("rst_valid",    32'(exc_valid),    32'd0);
            check("rst_cause",    32'(exc_cause),    32'd0);
            check("rst_prog",     32'(exc_prog),     32'd0);
            check("rst_pc",       32'(exc_pc),       32'd0);
            check("rst_overflow", 32'(exc_overflow), 32'd0);
            check("rst_count",    32'(exc_count),    32'd0);
            check("rst_operand",  32'(operand),      32'd0);
        end
        ProgState   = 2'd0;
        Instruction = NOP;
        PC          = 10'h000;
        DataIn      = 8'h00;
        exc_ack     = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        Reset = 1'b0;
        model_reset();
        cq.delete();
        last_valid = 0;
        mon_en = 1;
    endtask

    // monitor: compare every cycle, pop a record whenever a new one appears
    initial begin
        cyc_t e;
        rec_t r;
        bit   nr;
        forever begin
            @(negedge CLK);
            if (mon_en && cq.size() > 0) begin
                e = cq.pop_front();
                check("valid",    32'(exc_valid),    32'(e.v));
                check("overflow", 32'(exc_overflow), 32'(e.o));
                check("count",    32'(exc_count),    32'(e.c));
                check("operand",  32'(operand),      32'(e.op));
                nr = exc_valid && (!last_valid || exc_ack);
                if (nr) begin
                    if (rq.size() == 0) begin
                        check("record_unexpected", 32'd1, 32'd0);
                    end else begin
                        r = rq.pop_front();
                        check("rec_cause", 32'(exc_cause), 32'(r.cause));
                        check("rec_prog",  32'(exc_prog),  32'(r.prog));
                        check("rec_pc",    32'(exc_pc),    32'(r.pc));
                    end
                end
                last_valid = exc_valid;
            end
        end
    end

    initial begin
        logic [1:0] ps;
        logic [9:0] pc;
        int         sel;

        do_reset(1);

        // divide by zero in program 1
        cyc(1, lw(0), 10'h010, 8'h00, 0);
        cyc(1, lw(1), 10'h011, 8'h00, 0);
        cyc(1, NOP,   10'h03A, 8'h00, 0);
        cyc(1, NOP,   10'h03B, 8'h00, 0);
        check("t1_valid", 32'(exc_valid), 32'd1);
        check("t1_cause", 32'(exc_cause), 32'd1);
        check("t1_prog",  32'(exc_prog),  32'd1);
        check("t1_pc",    32'(exc_pc),    32'h03A);
        check("t1_count", 32'(exc_count), 32'd1);
        cyc(1, NOP, 10'h03C, 8'h00, 1);
        cyc(1, NOP, 10'h03D, 8'h00, 0);
        check("t1_ack", 32'(exc_valid), 32'd0);

        // nonzero divisor, PC held on the check address
        cyc(1, lw(0), 10'h020, 8'h00, 0);
        cyc(1, lw(1), 10'h021, 8'h05, 0);
        repeat (3) cyc(1, NOP, 10'h03A, 8'h00, 0);
        cyc(1, NOP, 10'h040, 8'h00, 0);
        check("t2_operand", 32'(operand),   32'h0005);
        check("t2_valid",   32'(exc_valid), 32'd0);

        // program 2, stalled check PC fires once
        cyc(2, NOP,   10'h050, 8'h00, 0);
        cyc(2, lw(2), 10'h051, 8'h00, 0);
        repeat (4) cyc(2, NOP, 10'h08D, 8'h00, 0);
        cyc(2, NOP, 10'h08E, 8'h00, 0);
        check("t3_pc",    32'(exc_pc),    32'h08D);
        check("t3_count", 32'(exc_count), 32'd2);
        cyc(2, NOP, 10'h08F, 8'h00, 1);
        cyc(2, NOP, 10'h090, 8'h00, 0);
        check("t3_ack", 32'(exc_valid), 32'd0);

        // overflow while pending
        cyc(2, NOP, 10'h08D, 8'h00, 0);
        cyc(2, NOP, 10'h3F5, 8'h00, 0);
        cyc(2, NOP, 10'h3F6, 8'h00, 0);
        check("t4_pc",  32'(exc_pc),       32'h08D);
        check("t4_ovf", 32'(exc_overflow), 32'd1);
        check("t4_cnt", 32'(exc_count),    32'd4);
        cyc(2, NOP, 10'h3F6, 8'h00, 1);
        cyc(2, NOP, 10'h010, 8'h00, 0);
        check("t4_ack_v", 32'(exc_valid),    32'd0);
        check("t4_ack_o", 32'(exc_overflow), 32'd0);

        // idle mid-capture clears lanes, then reset while pending
        cyc(1, NOP,   10'h011, 8'h00, 0);
        cyc(1, lw(0), 10'h012, 8'h12, 0);
        cyc(0, NOP,   10'h013, 8'h00, 0);
        cyc(1, NOP,   10'h014, 8'h00, 0);
        check("t5_operand", 32'(operand), 32'h0000);
        cyc(1, NOP, 10'h3F8, 8'h00, 0);
        cyc(1, NOP, 10'h010, 8'h00, 0);
        check("t5_pending", 32'(exc_valid), 32'd1);
        do_reset(1);

        // counter saturation
        for (int i = 0; i < 17; i++) begin
            cyc(1, NOP, 10'h3F5, 8'h00, 0);
            cyc(1, NOP, 10'h010, 8'h00, 1);
        end
        cyc(0, NOP, 10'h000, 8'h00, 0);
        check("t6_sat", 32'(exc_count), 32'hF);

        // random traffic
        do_reset(0);
        ps = 2'd1;
        pc = 10'h000;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) ps = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 5);
            case (sel)
                0:       pc = 10'h03A;
                1:       pc = 10'h08D;
                2:       pc = 10'h3F0 + 10'($urandom_range(0, 15));
                3:       pc = pc;
                default: pc = 10'($urandom_range(0, 1023));
            endcase
            cyc(ps,
                ($urandom_range(0, 1) == 1) ? lw($urandom_range(0, 7))
                                            : 9'($urandom),
                pc,
                ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom),
                ($urandom_range(0, 9) < 3));
        end
        repeat (3) cyc(0, NOP, 10'h000, 8'h00, 1);
        @(negedge CLK);
        #1;
        check("records_drained", 32'(rq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
